aftab_su_seq_divider: RTL and testbench
=======================================

Name: aftab_su_seq_divider

Overview:
- Self-contained, parametrised, sequential signed/unsigned radix-2 restoring divider for the AFTAB AAU.
- Successor to the separate divider datapath/controller pair. Controller, operand-sign handling and result-sign correction live in one block.
- Adds RISC-V divide-by-zero and signed-overflow semantics.
- Serves DIV/DIVU/REM/REMU through a start/done handshake.

Parameters:
- WIDTH, 32, operand/result width in bits (≥4).
- CNT_W, $clog2(WIDTH+1), iteration counter width.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- is_signed  in  1  1 = two's-complement operands, 0 = unsigned; captured with start
- dividend  in  WIDTH  numerator; captured with start
- divisor  in  WIDTH  denominator; captured with start
- busy  out  1  high from the cycle after accepted start until done cycle inclusive
- done  out  1  one-cycle pulse; results valid from this cycle on
- quotient  out  WIDTH  held until next accepted start
- remainder  out  WIDTH  held until next accepted start
- div_by_zero  out  1  valid with done, held
- overflow  out  1  signed MIN/-1 flag, valid with done, held

Behaviour:
- Reset: state=IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, overflow=0; counter=0.
- Reset mid-operation aborts immediately, with the same values next cycle. No partial result is ever presented.
- States:
  - IDLE: start=1 at edge k → capture operands, is_signed, magnitudes, and result signs.
    - neg_q = is_signed & (dividend[W-1] ^ divisor[W-1]).
    - neg_r = is_signed & dividend[W-1].
    - |x| is WIDTH-bit unsigned; |MIN| = 2^(W-1) fits.
    - If divisor==0 or signed overflow → SPECIAL, else → CALC with R=0 (WIDTH+1 bits), Q=|dividend|, M={0,|divisor|}, count=0.
  - CALC: one iteration per cycle, exactly WIDTH cycles.
    - Per cycle: {R,Q} shifted left 1; trial = R_sh − M.
    - trial MSB=0 → R=trial, Q[0]=1; else R=R_sh (restore), Q[0]=0.
    - count==WIDTH-1 → FIX.
  - FIX: quotient = neg_q ? −Q : Q; remainder = neg_r ? −R[W-1:0] : R[W-1:0]; flags=0 → DONE.
  - SPECIAL:
    - Divide by zero: quotient = all ones, remainder = original dividend, div_by_zero=1, overflow=0.
    - Signed overflow (dividend = 1 followed by zeros, divisor = all ones, is_signed=1): quotient = dividend, remainder = 0, overflow=1, div_by_zero=0.
    - Divide by zero takes priority → DONE.
  - DONE: done=1, busy=1 for one cycle → IDLE.
- Latency:
  - Normal: start edge k; done high in cycle after edge k+WIDTH+1, i.e. WIDTH+2 cycles.
  - Special: done high after edge k+1, i.e. 2 cycles.
- Handshake:
  - start while busy (CALC/FIX/SPECIAL/DONE) is ignored and not queued.
  - start in the cycle immediately after DONE (IDLE) is accepted. Back-to-back throughput is WIDTH+3 cycles.
  - Input operands may change freely after the accepting edge.
- Width rules:
  - Trial subtraction is WIDTH+1 bits; the sign is the MSB of the trial.
  - Negation is two's complement modulo 2^WIDTH.
  - Unsigned mode never sets overflow.
  - Zero dividend follows the normal path: q=0, r=0.
- Quotient/remainder/flags change only on the FIX or SPECIAL edge and on reset.

Decomposition:
- Package aftab_div_pkg:
  - state enum (IDLE, CALC, FIX, SPECIAL, DONE, 3-bit);
  - function abs_w;
  - function neg_w;
  - localparam for MIN pattern generation.
- One combinational sub-module, aftab_div_restore_step (WIDTH):
  - inputs R, Q, M;
  - outputs next R, next Q.
  - Isolates the iteration step for unit checking.
- Everything else stays in the top module.

Test Plan:
1. WIDTH=32, unsigned 100/7 → quotient=14, remainder=2, flags 0. done exactly 34 cycles after start edge; busy high 34 cycles.
2. Signed −7/2 (0xFFFFFFF9/0x00000002) → quotient=0xFFFFFFFD, remainder=0xFFFFFFFF. Signed 7/−2 → quotient=0xFFFFFFFD, remainder=0x00000001.
3. Divide by zero: 0x00001234/0, signed and unsigned → quotient=0xFFFFFFFF, remainder=0x00001234, div_by_zero=1, done 2 cycles after start.
4. 0x80000000/0xFFFFFFFF:
   - signed → quotient=0x80000000, remainder=0, overflow=1, 2-cycle latency;
   - unsigned → quotient=0, remainder=0x80000000, overflow=0, 34-cycle latency.
5. Start held high during CALC with different operands → ignored, result unchanged. New start in the cycle after done → accepted, second result correct.
6. rst asserted during CALC iteration 10 → next cycle busy=0, done=0, all outputs 0. A subsequent 0xFFFFFFFF/0x10 unsigned run → quotient=0x0FFFFFFF, remainder=0xF.

Source files
------------

// File: rtl/aftab_div_pkg.sv
// Shared types and width-generic helpers for the AFTAB sequential divider.
// Helpers work on a 64-bit carrier; callers pass the live width and truncate.
package aftab_div_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CALC    = 3'd1,
        FIX     = 3'd2,
        SPECIAL = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam int DIV_MAX_W = 64;

    typedef logic [DIV_MAX_W-1:0] wide_t;

    function automatic wide_t width_mask(input int w);
        return (w >= DIV_MAX_W) ? '1 : ((wide_t'(1) << w) - wide_t'(1));
    endfunction

    // Most negative two's-complement value of width w: 1 followed by zeros.
    function automatic wide_t min_w(input int w);
        return wide_t'(1) << (w - 1);
    endfunction

    function automatic wide_t neg_w(input wide_t x, input int w);
        return (~x + wide_t'(1)) & width_mask(w);
    endfunction

    // |MIN| comes out as 2^(w-1), which still fits the unsigned w-bit result.
    function automatic wide_t abs_w(input wide_t x, input int w, input logic sgn);
        return (sgn && x[w-1]) ? neg_w(x, w) : (x & width_mask(w));
    endfunction

endpackage

// File: rtl/aftab_div_restore_step.sv
// One radix-2 restoring division iteration: shift {R,Q}, trial-subtract M,
// keep the difference and set the quotient bit when it is non-negative.
module aftab_div_restore_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   r,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH:0]   m,
    output logic [WIDTH:0]   r_next,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH:0] r_sh;
    logic [WIDTH:0] trial;
    logic           unused_r_msb;

    // R stays below M, so its top bit is always clear and drops out of the shift.
    assign unused_r_msb = r[WIDTH];
    assign r_sh         = {r[WIDTH-1:0], q[WIDTH-1]};
    assign trial        = r_sh - m;

    always_comb begin
        r_next = r_sh;
        q_next = {q[WIDTH-2:0], 1'b0};
        if (!trial[WIDTH]) begin
            r_next    = trial;
            q_next[0] = 1'b1;
        end
    end

endmodule

// File: rtl/aftab_su_seq_divider.sv
// Sequential signed/unsigned restoring divider with RISC-V divide-by-zero and
// MIN/-1 overflow handling behind a start/done handshake.
module aftab_su_seq_divider
    import aftab_div_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam logic [WIDTH-1:0] MIN_PAT = WIDTH'(min_w(WIDTH));

    state_t           state, state_n;
    logic [WIDTH:0]   r_acc, r_nx, m_acc;
    logic [WIDTH-1:0] q_acc, q_nx, dvd_orig;
    logic [CNT_W-1:0] cnt;
    logic             neg_q, neg_r, dz_q;
    logic             dz_in, ov_in;
    logic [WIDTH-1:0] dvd_abs, dvs_abs;

    assign dz_in   = (divisor == '0);
    assign ov_in   = is_signed && (dividend == MIN_PAT) && (divisor == '1);
    assign dvd_abs = WIDTH'(abs_w(wide_t'(dividend), WIDTH, is_signed));
    assign dvs_abs = WIDTH'(abs_w(wide_t'(divisor), WIDTH, is_signed));

    aftab_div_restore_step #(.WIDTH(WIDTH)) u_step (
        .r      (r_acc),
        .q      (q_acc),
        .m      (m_acc),
        .r_next (r_nx),
        .q_next (q_nx)
    );

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = (dz_in || ov_in) ? SPECIAL : CALC;
            CALC:    if (cnt == CNT_W'(WIDTH - 1)) state_n = FIX;
            FIX:     state_n = DONE;
            SPECIAL: state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            r_acc       <= '0;
            q_acc       <= '0;
            m_acc       <= '0;
            dvd_orig    <= '0;
            cnt         <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            dz_q        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            state <= state_n;
            case (state)
                IDLE: if (start) begin
                    r_acc    <= '0;
                    q_acc    <= dvd_abs;
                    m_acc    <= {1'b0, dvs_abs};
                    dvd_orig <= dividend;
                    cnt      <= '0;
                    neg_q    <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                    neg_r    <= is_signed & dividend[WIDTH-1];
                    dz_q     <= dz_in;
                end
                CALC: begin
                    r_acc <= r_nx;
                    q_acc <= q_nx;
                    cnt   <= cnt + 1'b1;
                end
                FIX: begin
                    quotient    <= neg_q ? WIDTH'(neg_w(wide_t'(q_acc), WIDTH)) : q_acc;
                    remainder   <= neg_r ? WIDTH'(neg_w(wide_t'(r_acc[WIDTH-1:0]), WIDTH))
                                         : r_acc[WIDTH-1:0];
                    div_by_zero <= 1'b0;
                    overflow    <= 1'b0;
                end
                SPECIAL: begin
                    // Only reached for /0 or MIN/-1; /0 wins when both hold.
                    if (dz_q) begin
                        quotient    <= '1;
                        remainder   <= dvd_orig;
                        div_by_zero <= 1'b1;
                        overflow    <= 1'b0;
                    end else begin
                        quotient    <= dvd_orig;
                        remainder   <= '0;
                        div_by_zero <= 1'b0;
                        overflow    <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aftab_su_seq_divider.sv
// Scoreboard bench for aftab_su_seq_divider at WIDTH=32: expected results are
// queued at issue time from a behavioural RISC-V division model.
module tb_aftab_su_seq_divider;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst, start, is_signed;
    logic [W-1:0] dividend, divisor;
    logic         busy, done, div_by_zero, overflow;
    logic [W-1:0] quotient, remainder;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        logic         ov;
        int           lat;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    aftab_su_seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    // lat = rising edges from the accepting edge to the edge that raises done.
    function automatic exp_t model(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        e.dz  = 1'b0;
        e.ov  = 1'b0;
        e.lat = W + 1;
        if (b == 0) begin
            e.q = '1; e.r = a; e.dz = 1'b1; e.lat = 1;
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.q = a; e.r = '0; e.ov = 1'b1; e.lat = 1;
        end else if (sgn) begin
            e.q = $signed(a) / $signed(b);
            e.r = $signed(a) % $signed(b);
        end else begin
            e.q = a / b;
            e.r = a % b;
        end
        return e;
    endfunction

    // Issue one op, then wait (bounded) for done. With hold, start stays high
    // with scrambled operands while the DUT is busy.
    task automatic run(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit hold, output int lat, output int bcnt);
        @(negedge clk);
        is_signed = sgn; dividend = a; divisor = b; start = 1'b1;
        sb.push_back(model(sgn, a, b));
        @(posedge clk);
        lat  = -1;
        bcnt = 0;
        for (int e = 0; e < 200; e++) begin
            @(negedge clk);
            if (hold) begin
                dividend  = $urandom;
                divisor   = $urandom | 32'h1;
                is_signed = ~sgn;
            end else begin
                start = 1'b0;
            end
            if (busy) bcnt++;
            if (done) begin
                lat = e;
                break;
            end
            @(posedge clk);
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if ({busy, done, div_by_zero, overflow, quotient, remainder} !== '0) begin
            n_miss++;
            $display("FAIL reset: busy=%b done=%b dz=%b ov=%b q=%h r=%h, want all zero",
                     busy, done, div_by_zero, overflow, quotient, remainder);
        end
        rst = 1'b0;
    endtask

    task automatic test_unsigned();
        logic [W-1:0] as [5] = '{32'd100, 32'd0, 32'hFFFF_FFFF, 32'h8000_0000, 32'd5};
        logic [W-1:0] bs [5] = '{32'd7, 32'd5, 32'd1, 32'hFFFF_FFFF, 32'd9};
        int lat, bcnt;
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            run(1'b0, as[i], bs[i], 1'b0, lat, bcnt);
            e = sb.pop_front();
            n_vec += 6;
            if (quotient !== e.q) begin n_miss++; $display("FAIL unsigned[%0d] quotient got %h want %h", i, quotient, e.q); end
            if (remainder !== e.r) begin n_miss++; $display("FAIL unsigned[%0d] remainder got %h want %h", i, remainder, e.r); end
            if (div_by_zero !== e.dz) begin n_miss++; $display("FAIL unsigned[%0d] div_by_zero got %b want %b", i, div_by_zero, e.dz); end
            if (overflow !== e.ov) begin n_miss++; $display("FAIL unsigned[%0d] overflow got %b want %b", i, overflow, e.ov); end
            if (lat !== e.lat) begin n_miss++; $display("FAIL unsigned[%0d] latency got %0d want %0d", i, lat, e.lat); end
            if (bcnt !== e.lat + 1) begin n_miss++; $display("FAIL unsigned[%0d] busy_cycles got %0d want %0d", i, bcnt, e.lat + 1); end
        end
    endtask

    task automatic test_signed();
        logic [W-1:0] as [5] = '{32'hFFFF_FFF9, 32'd7, 32'hFFFF_FFF9, 32'h8000_0000, 32'h8000_0000};
        logic [W-1:0] bs [5] = '{32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'd2, 32'h8000_0000};
        int lat, bcnt;
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            run(1'b1, as[i], bs[i], 1'b0, lat, bcnt);
            e = sb.pop_front();
            n_vec += 6;
            if (quotient !== e.q) begin n_miss++; $display("FAIL signed[%0d] quotient got %h want %h", i, quotient, e.q); end
            if (remainder !== e.r) begin n_miss++; $display("FAIL signed[%0d] remainder got %h want %h", i, remainder, e.r); end
            if (div_by_zero !== e.dz) begin n_miss++; $display("FAIL signed[%0d] div_by_zero got %b want %b", i, div_by_zero, e.dz); end
            if (overflow !== e.ov) begin n_miss++; $display("FAIL signed[%0d] overflow got %b want %b", i, overflow, e.ov); end
            if (lat !== e.lat) begin n_miss++; $display("FAIL signed[%0d] latency got %0d want %0d", i, lat, e.lat); end
            if (bcnt !== e.lat + 1) begin n_miss++; $display("FAIL signed[%0d] busy_cycles got %0d want %0d", i, bcnt, e.lat + 1); end
        end
    endtask

    task automatic test_special();
        bit           sg [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic [W-1:0] as [4] = '{32'h0000_1234, 32'h0000_1234, 32'h8000_0000, 32'h8000_0000};
        logic [W-1:0] bs [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0};
        int lat, bcnt;
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            run(sg[i], as[i], bs[i], 1'b0, lat, bcnt);
            e = sb.pop_front();
            n_vec += 6;
            if (quotient !== e.q) begin n_miss++; $display("FAIL special[%0d] quotient got %h want %h", i, quotient, e.q); end
            if (remainder !== e.r) begin n_miss++; $display("FAIL special[%0d] remainder got %h want %h", i, remainder, e.r); end
            if (div_by_zero !== e.dz) begin n_miss++; $display("FAIL special[%0d] div_by_zero got %b want %b", i, div_by_zero, e.dz); end
            if (overflow !== e.ov) begin n_miss++; $display("FAIL special[%0d] overflow got %b want %b", i, overflow, e.ov); end
            if (lat !== e.lat) begin n_miss++; $display("FAIL special[%0d] latency got %0d want %0d", i, lat, e.lat); end
            if (bcnt !== e.lat + 1) begin n_miss++; $display("FAIL special[%0d] busy_cycles got %0d want %0d", i, bcnt, e.lat + 1); end
        end
    endtask

    task automatic test_back_to_back();
        bit           sg  [3] = '{1'b0, 1'b1, 1'b0};
        logic [W-1:0] as  [3] = '{32'd1000, 32'hFFFF_FF9C, 32'h1234_5678};
        logic [W-1:0] bs  [3] = '{32'd3, 32'd7, 32'h0000_0100};
        bit           hld [3] = '{1'b1, 1'b0, 1'b0};
        int lat, bcnt;
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            run(sg[i], as[i], bs[i], hld[i], lat, bcnt);
            e = sb.pop_front();
            n_vec += 5;
            if (quotient !== e.q) begin n_miss++; $display("FAIL b2b[%0d] quotient got %h want %h", i, quotient, e.q); end
            if (remainder !== e.r) begin n_miss++; $display("FAIL b2b[%0d] remainder got %h want %h", i, remainder, e.r); end
            if ({div_by_zero, overflow} !== {e.dz, e.ov}) begin n_miss++; $display("FAIL b2b[%0d] flags got %b%b want %b%b", i, div_by_zero, overflow, e.dz, e.ov); end
            if (lat !== e.lat) begin n_miss++; $display("FAIL b2b[%0d] latency got %0d want %0d", i, lat, e.lat); end
            if (bcnt !== e.lat + 1) begin n_miss++; $display("FAIL b2b[%0d] busy_cycles got %0d want %0d", i, bcnt, e.lat + 1); end
            if (hld[i]) begin
                // A start seen while busy must not have been queued.
                @(negedge clk);
                n_vec++;
                if ({busy, done} !== 2'b00) begin n_miss++; $display("FAIL b2b_not_queued busy/done got %b%b want 00", busy, done); end
            end
        end
    endtask

    task automatic test_abort();
        int lat, bcnt;
        exp_t e;
        @(negedge clk);
        is_signed = 1'b0; dividend = 32'd123456; divisor = 32'd789; start = 1'b1;
        sb.push_back(model(1'b0, 32'd123456, 32'd789));
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        void'(sb.pop_front());
        @(posedge clk);
        @(negedge clk);
        n_vec++;
        if ({busy, done, div_by_zero, overflow, quotient, remainder} !== '0) begin
            n_miss++;
            $display("FAIL abort: busy=%b done=%b dz=%b ov=%b q=%h r=%h, want all zero",
                     busy, done, div_by_zero, overflow, quotient, remainder);
        end
        rst = 1'b0;
        run(1'b0, 32'hFFFF_FFFF, 32'h10, 1'b0, lat, bcnt);
        e = sb.pop_front();
        n_vec += 4;
        if (quotient !== e.q) begin n_miss++; $display("FAIL after_abort quotient got %h want %h", quotient, e.q); end
        if (remainder !== e.r) begin n_miss++; $display("FAIL after_abort remainder got %h want %h", remainder, e.r); end
        if ({div_by_zero, overflow} !== {e.dz, e.ov}) begin n_miss++; $display("FAIL after_abort flags got %b%b want %b%b", div_by_zero, overflow, e.dz, e.ov); end
        if (lat !== e.lat) begin n_miss++; $display("FAIL after_abort latency got %0d want %0d", lat, e.lat); end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_special();
        test_back_to_back();
        test_abort();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
